serial_add_sub: RTL and testbench

Parametrised, multi-cycle adder/subtractor. It processes `WIDTH`-bit operands `DIGIT` bits per clock, LSB first, using a ripple of `DIGIT` full-adder cells and a registered inter-digit carry. `sel` chooses the operation: 0 for add, 1 for subtract (b is inverted and the carry-in seeded with 1). It sits beside the combinational 4-bit adder/subtractor as the area-efficient, wide-operand option. A start/busy/done handshake lets it be driven by a controller or bench, and it reports carry, signed overflow and zero flags.

---
 rtl/serial_add_sub.sv | 106 ++++++++++
 tb/tb_serial_add_sub.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock, LSB first,
// with a start/busy/done handshake and carry, signed-overflow and zero flags.
module serial_add_sub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic [WIDTH-1:0]       sa, sb, part;
    logic                   ssel, carry;
    logic [CW-1:0]          cnt;

    logic [DIGIT-1:0]       bd, dsum;
    logic                   c, dcarry, cmsb, last;
    logic [WIDTH+DIGIT-1:0] cat;
    logic [WIDTH-1:0]       nxt_part;

    // One digit of ripple-carry; cmsb keeps the carry into the top cell of the
    // digit, which on the final digit is the carry into bit WIDTH-1.
    always_comb begin
        bd   = sb[DIGIT-1:0] ^ {DIGIT{ssel}};
        c    = carry;
        cmsb = carry;
        dsum = '0;
        for (int unsigned i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) cmsb = c;
            dsum[i] = sa[i] ^ bd[i] ^ c;
            c       = (sa[i] & bd[i]) | (c & (sa[i] ^ bd[i]));
        end
        dcarry   = c;
        cat      = {dsum, part};
        nxt_part = cat[WIDTH+DIGIT-1:DIGIT];
        last     = (cnt == CW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            part  <= '0;
            ssel  <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            out   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        ssel  <= sel;
                        carry <= sel;
                        cnt   <= '0;
                        part  <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sa    <= sa >> DIGIT;
                    sb    <= sb >> DIGIT;
                    part  <= nxt_part;
                    carry <= dcarry;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        out   <= nxt_part;
                        c_out <= dcarry;
                        ovf   <= cmsb ^ dcarry;
                        zero  <= (nxt_part == '0);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: an 8x1 and a 16x4 instance, directed
// cases plus randomized operations against an arithmetic reference model.
module tb_serial_add_sub;
    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0, sel8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, out8;
    logic        busy8, done8, c8, v8, z8;

    logic        start16 = 1'b0, sel16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, out16;
    logic        busy16, done16, c16, v16, z16;

    int          cur = 8;
    int          checks = 0;
    int          failures = 0;

    logic        o_busy, o_done, o_c, o_v, o_z;
    logic [15:0] o_out;

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sel(sel8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .out(out8), .c_out(c8), .ovf(v8), .zero(z8)
    );

    serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sel(sel16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .out(out16), .c_out(c16), .ovf(v16), .zero(z16)
    );

    always #5 clk = ~clk;

    always_comb begin
        o_busy = (cur == 8) ? busy8 : busy16;
        o_done = (cur == 8) ? done8 : done16;
        o_out  = (cur == 8) ? {8'h00, out8} : out16;
        o_c    = (cur == 8) ? c8 : c16;
        o_v    = (cur == 8) ? v8 : v16;
        o_z    = (cur == 8) ? z8 : z16;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Result packed as {zero, ovf, c_out, out[15:0]}, derived from integer arithmetic.
    function automatic logic [18:0] ref_op(input int w, input logic s,
                                           input logic [15:0] x, input logic [15:0] y);
        int xa, yb, xs, ys, r, rs, half, full;
        logic [15:0] res;
        logic c, v;
        full = 1 << w;
        half = 1 << (w - 1);
        xa = int'(x) % full;
        yb = int'(y) % full;
        xs = (xa >= half) ? xa - full : xa;
        ys = (yb >= half) ? yb - full : yb;
        r  = s ? xa - yb : xa + yb;
        rs = s ? xs - ys : xs + ys;
        res = 16'(r & (full - 1));
        c = s ? (xa >= yb) : (xa + yb >= full);
        v = (rs < -half) || (rs > half - 1);
        return {res == 16'h0, v, c, res};
    endfunction

    task automatic drive(input int w, input logic s, input logic [15:0] x,
                         input logic [15:0] y, input logic st);
        if (w == 8) begin
            start8 = st; sel8 = s; a8 = x[7:0]; b8 = y[7:0];
        end else begin
            start16 = st; sel16 = s; a16 = x; b16 = y;
        end
    endtask

    // Called #1 after the edge that accepted start; waits (bounded) for done.
    task automatic wait_result(input string tag, input logic [18:0] exp, input int expn);
        int bc, cnt;
        logic [15:0] m;
        bc  = 0;
        cnt = 0;
        while (!o_done && cnt < 40) begin
            if (o_busy) bc++;
            @(posedge clk); #1;
            cnt++;
        end
        m = (cur == 8) ? 16'h00FF : 16'hFFFF;
        check({tag, ".busylen"}, bc, expn);
        check({tag, ".done"}, o_done, 1);
        check({tag, ".out"}, o_out & m, exp[15:0] & m);
        check({tag, ".c_out"}, o_c, exp[16]);
        check({tag, ".ovf"}, o_v, exp[17]);
        check({tag, ".zero"}, o_z, exp[18]);
    endtask

    task automatic run_op(input string tag, input int w, input logic s,
                          input logic [15:0] x, input logic [15:0] y, input logic [18:0] exp);
        cur = w;
        drive(w, s, x, y, 1'b1);
        @(posedge clk); #1;
        drive(w, 1'($urandom), 16'($urandom), 16'($urandom), 1'b0);
        wait_result(tag, exp, (w == 8) ? 8 : 4);
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, o_done, 0);
        check({tag, ".idle"}, o_busy, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] qa[4], qb[4];
        logic        qs[4];
        logic [18:0] qe[4];
        logic [18:0] e;
        logic        s;
        logic [15:0] x, y;
        int          nd;

        repeat (3) @(posedge clk);
        #1;
        for (int w = 8; w <= 16; w += 8) begin
            cur = w;
            #0;
            check("rst.busy", o_busy, 0);
            check("rst.done", o_done, 0);
            check("rst.out", o_out, 0);
            check("rst.flags", {o_c, o_v, o_z}, 0);
        end
        rst = 1'b0;

        // Directed 8-bit cases; expected {zero, ovf, c_out, out}.
        run_op("add6_3",   8, 1'b0, 16'h06, 16'h03, {1'b0, 1'b0, 1'b0, 16'h0009});
        run_op("sub7_2",   8, 1'b1, 16'h07, 16'h02, {1'b0, 1'b0, 1'b1, 16'h0005});
        run_op("sub3_5",   8, 1'b1, 16'h03, 16'h05, {1'b0, 1'b0, 1'b0, 16'h00FE});
        run_op("add7f_1",  8, 1'b0, 16'h7F, 16'h01, {1'b0, 1'b1, 1'b0, 16'h0080});
        run_op("sub55_55", 8, 1'b1, 16'h55, 16'h55, {1'b1, 1'b0, 1'b1, 16'h0000});
        run_op("sub16",   16, 1'b1, 16'h1234, 16'h0235, {1'b0, 1'b0, 1'b1, 16'h0FFF});

        // start during RUN is ignored.
        cur = 8;
        drive(8, 1'b0, 16'd10, 16'd20, 1'b1);
        @(posedge clk); #1;
        drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        drive(8, 1'b1, 16'd1, 16'd2, 1'b1);
        @(posedge clk); #1;
        drive(8, 1'b1, 16'd1, 16'd2, 1'b0);
        wait_result("ignore", {1'b0, 1'b0, 1'b0, 16'h001E}, 5);
        nd = 0;
        repeat (12) begin @(posedge clk); #1; if (o_done) nd++; end
        check("ignore.extra_done", nd, 0);
        check("ignore.held", o_out, 16'h001E);

        // Back-to-back with start held high.
        for (int k = 0; k < 4; k++) begin
            qs[k] = 1'($urandom);
            qa[k] = 16'($urandom_range(0, 255));
            qb[k] = 16'($urandom_range(0, 255));
            qe[k] = ref_op(8, qs[k], qa[k], qb[k]);
        end
        drive(8, qs[0], qa[0], qb[0], 1'b1);
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) check("b2b.hold_in_run", o_out, {8'h00, qe[k-1][7:0]});
            if (k < 3) drive(8, qs[k+1], qa[k+1], qb[k+1], 1'b1);
            else       drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
            wait_result("b2b", qe[k], 8);
            @(posedge clk); #1;
        end
        check("b2b.end_done", o_done, 0);

        // Reset four cycles into RUN.
        run_op("pre_rst", 8, 1'b0, 16'h06, 16'h03, {1'b0, 1'b0, 1'b0, 16'h0009});
        drive(8, 1'b1, 16'h40, 16'h01, 1'b1);
        @(posedge clk); #1;
        drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst.busy", o_busy, 0);
        check("midrst.done", o_done, 0);
        check("midrst.out", o_out, 0);
        check("midrst.flags", {o_c, o_v, o_z}, 0);
        nd = 0;
        repeat (15) begin @(posedge clk); #1; if (o_done) nd++; end
        check("midrst.no_done", nd, 0);

        // Randomized operations on both instances against the reference model.
        for (int k = 0; k < 1000; k++) begin
            int w;
            w = (k % 2 == 1) ? 16 : 8;
            s = 1'($urandom);
            x = 16'($urandom);
            y = 16'($urandom);
            if (w == 8) begin x[15:8] = '0; y[15:8] = '0; end
            e = ref_op(w, s, x, y);
            run_op((w == 8) ? "rand8" : "rand16", w, s, x, y, e);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
